clk_div_burst: RTL

//  Consumes the free-running clk produced by the clock generator stage.

---
 rtl/clk_div_burst.sv | 136 +++++++++++++
 1 files changed

// File: rtl/clk_div_burst.sv
// Programmable clock divider with free-run and counted-burst modes.
// Produces a registered divided clock, a tick strobe, busy/done status and a tick counter.
module clk_div_burst #(
    parameter int WIDTH       = 8,
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             mode,
    input  logic             start,
    input  logic [CNT_W-1:0] burst_len,
    input  logic             div_load,
    input  logic [WIDTH-1:0] div_in,
    output logic             clk_div,
    output logic             tick,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pulses
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_BURST,
        S_DONE
    } state_t;

    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] w_div_nxt;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] w_len_nxt;
    logic [CNT_W-1:0] r_pulses;
    logic [CNT_W-1:0] w_pulses_nxt;
    logic             r_clk_div;
    logic             w_clk_div_nxt;
    logic             w_busy;
    logic             w_busy_nxt;
    logic             w_last;
    logic             w_tick;
    logic [WIDTH-1:0] w_div_clamped;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_div     <= DIV_RST;
            r_cnt     <= '0;
            r_len     <= '0;
            r_pulses  <= '0;
            r_clk_div <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_div     <= w_div_nxt;
            r_cnt     <= w_cnt_nxt;
            r_len     <= w_len_nxt;
            r_pulses  <= w_pulses_nxt;
            r_clk_div <= w_clk_div_nxt;
        end
    end

    always_comb begin
        w_busy        = (r_state == S_RUN) || (r_state == S_BURST);
        w_last        = (r_cnt == r_div - WIDTH'(1));
        w_tick        = w_busy && w_last;
        w_div_clamped = (div_in < WIDTH'(2)) ? WIDTH'(2) : div_in;

        w_state_nxt  = r_state;
        w_div_nxt    = r_div;
        w_len_nxt    = r_len;
        w_pulses_nxt = w_tick ? r_pulses + CNT_W'(1) : r_pulses;
        w_cnt_nxt    = '0;
        if (w_busy) begin
            w_cnt_nxt = w_last ? '0 : r_cnt + WIDTH'(1);
        end

        unique case (r_state)
            S_IDLE: begin
                if (div_load) begin
                    w_div_nxt = w_div_clamped;
                end
                if (en && !mode) begin
                    w_state_nxt  = S_RUN;
                    w_pulses_nxt = '0;
                end else if (en && mode && start) begin
                    if (burst_len != '0) begin
                        w_state_nxt  = S_BURST;
                        w_len_nxt    = burst_len;
                        w_pulses_nxt = '0;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (!en || mode) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            S_BURST: begin
                // Abort on !en wins over a completion landing on the same edge.
                if (!en) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_tick && (r_pulses + CNT_W'(1) == r_len)) begin
                    w_state_nxt = S_DONE;
                    w_cnt_nxt   = '0;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // clk_div tracks the count value being loaded, gated by the state being entered.
        w_busy_nxt    = (w_state_nxt == S_RUN) || (w_state_nxt == S_BURST);
        w_clk_div_nxt = w_busy_nxt && (w_cnt_nxt < (w_div_nxt >> 1));
    end

    assign clk_div = r_clk_div;
    assign tick    = w_tick;
    assign busy    = w_busy;
    assign done    = (r_state == S_DONE);
    assign pulses  = r_pulses;

endmodule
